// File: rtl/idu_seq.sv
// idu_seq: two-entry skid-buffered instruction-decode sequencer between IFU and EXU
module idu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             ifu_valid,
  output logic             ifu_ready,
  input  logic [XLEN-1:0]  ifu_inst,
  input  logic [XLEN-1:0]  ifu_pc,
  output logic             idu_valid,
  input  logic             idu_ready,
  output logic [XLEN-1:0]  idu_inst,
  output logic [XLEN-1:0]  idu_pc,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [2:0]       type3,
  output logic             ill,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [2:0] INST_R   = 3'd0;
  localparam logic [2:0] INST_I   = 3'd1;
  localparam logic [2:0] INST_S   = 3'd2;
  localparam logic [2:0] INST_B   = 3'd3;
  localparam logic [2:0] INST_U   = 3'd4;
  localparam logic [2:0] INST_J   = 3'd5;
  localparam logic [2:0] INST_ILL = 3'd7;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [2:0]      type3;
    logic            ill;
  } entry_t;
  state_e           state_q, state_d;
  entry_t           head_q, head_d, skid_q, skid_d, in_e;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       fmt;
  logic             use_rd, use_rs1, use_rs2, bad_reg, enq, deq;
  // classify the incoming word so only stored results reach the outputs
  always_comb begin
    unique case (ifu_inst[6:0])
      7'b0110011:                                     fmt = INST_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt = INST_I;
      7'b0100011:                                     fmt = INST_S;
      7'b1100011:                                     fmt = INST_B;
      7'b0110111, 7'b0010111:                         fmt = INST_U;
      7'b1101111:                                     fmt = INST_J;
      default:                                        fmt = INST_ILL;
    endcase
    use_rd  = fmt == INST_R || fmt == INST_I || fmt == INST_U || fmt == INST_J;
    use_rs1 = fmt == INST_R || fmt == INST_I || fmt == INST_S || fmt == INST_B;
    use_rs2 = fmt == INST_R || fmt == INST_S || fmt == INST_B;
    bad_reg = (use_rd && ifu_inst[11]) || (use_rs1 && ifu_inst[19]) || (use_rs2 && ifu_inst[24]);
    in_e.inst  = ifu_inst;
    in_e.pc    = ifu_pc;
    in_e.ill   = fmt == INST_ILL || bad_reg;
    in_e.type3 = in_e.ill ? INST_ILL : fmt;
  end
  assign ifu_ready = state_q != TWO && !rst;
  assign idu_valid = state_q != EMPTY;
  assign enq       = ifu_valid && ifu_ready;
  assign deq       = idu_valid && idu_ready;
  // buffer next-state: flush empties both entries and ignores the handshake
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) state_d = EMPTY;
    else if (state_q == EMPTY && enq) begin
      state_d = ONE;
      head_d  = in_e;
    end else if (state_q == ONE && enq) begin
      state_d = deq ? ONE : TWO;
      head_d  = deq ? in_e : head_q;
      skid_d  = deq ? skid_q : in_e;
    end else if (state_q == ONE && deq) state_d = EMPTY;
    else if (state_q == TWO && deq) begin
      state_d = ONE;
      head_d  = skid_q;
    end
    cnt_d = (idu_valid && !idu_ready && !flush && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  // state, entries and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end
  assign idu_inst  = head_q.inst;
  assign idu_pc    = head_q.pc;
  assign rs1       = head_q.inst[19:15];
  assign rs2       = head_q.inst[24:20];
  assign rd        = head_q.inst[11:7];
  assign funct3    = head_q.inst[14:12];
  assign funct7    = head_q.inst[31:25];
  assign type3     = head_q.type3;
  assign ill       = head_q.ill;
  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_idu_seq.sv
// tb_idu_seq: directed self-checking bench for idu_seq
module tb_idu_seq;
  logic        clk = 0, rst = 1, flush = 0, ifu_valid = 1, idu_ready = 0;
  logic [31:0] ifu_inst = 32'h00510093, ifu_pc = 32'h80000000;
  logic        ifu_ready, idu_valid, ill;
  logic [31:0] idu_inst, idu_pc, stall_cnt;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3, type3;
  logic [6:0]  funct7;
  logic        s_ifu_ready, s_idu_valid, s_ill;
  logic [31:0] s_idu_inst, s_idu_pc;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [2:0]  s_funct3, s_type3;
  logic [6:0]  s_funct7;
  logic [3:0]  s_stall_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  idu_seq dut (.clk(clk), .rst(rst), .flush(flush), .ifu_valid(ifu_valid), .ifu_ready(ifu_ready),
    .ifu_inst(ifu_inst), .ifu_pc(ifu_pc), .idu_valid(idu_valid), .idu_ready(idu_ready),
    .idu_inst(idu_inst), .idu_pc(idu_pc), .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3),
    .funct7(funct7), .type3(type3), .ill(ill), .stall_cnt(stall_cnt));
  idu_seq #(.CNT_W(4)) dut4 (.clk(clk), .rst(rst), .flush(flush), .ifu_valid(ifu_valid),
    .ifu_ready(s_ifu_ready), .ifu_inst(ifu_inst), .ifu_pc(ifu_pc), .idu_valid(s_idu_valid),
    .idu_ready(idu_ready), .idu_inst(s_idu_inst), .idu_pc(s_idu_pc), .rs1(s_rs1), .rs2(s_rs2),
    .rd(s_rd), .funct3(s_funct3), .funct7(s_funct7), .type3(s_type3), .ill(s_ill),
    .stall_cnt(s_stall_cnt));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ifu_ready", 32'(ifu_ready), 0);
      chk("rst_idu_valid", 32'(idu_valid), 0);
    end
    rst = 0;
    ifu_valid = 0;
    #1;
    chk("post_rst_ifu_ready", 32'(ifu_ready), 1);
    chk("post_rst_idu_valid", 32'(idu_valid), 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_idu_inst", idu_inst, 0);
    chk("rst_type3", 32'(type3), 0);
    chk("rst_ill", 32'(ill), 0);
    idu_ready = 1;
    ifu_valid = 1;
    ifu_inst = 32'h00510093;
    ifu_pc = 32'h80000000;
    tick();
    chk("addi_valid", 32'(idu_valid), 1);
    chk("addi_type3", 32'(type3), 1);
    chk("addi_rs1", 32'(rs1), 2);
    chk("addi_rd", 32'(rd), 1);
    chk("addi_funct7", 32'(funct7), 0);
    chk("addi_rs2", 32'(rs2), 5);
    chk("addi_pc", idu_pc, 32'h80000000);
    ifu_inst = 32'h008000EF;
    ifu_pc = 32'h80000004;
    tick();
    chk("jal_type3", 32'(type3), 5);
    chk("jal_pc", idu_pc, 32'h80000004);
    chk("jal_ill", 32'(ill), 0);
    ifu_valid = 0;
    tick();
    chk("drain_valid", 32'(idu_valid), 0);
    chk("stream_stall_cnt", stall_cnt, 0);
    idu_ready = 0;
    ifu_valid = 1;
    ifu_inst = 32'h00510093;
    ifu_pc = 32'h100;
    tick();
    chk("bp_ready_after1", 32'(ifu_ready), 1);
    ifu_inst = 32'h008000EF;
    ifu_pc = 32'h104;
    tick();
    chk("bp_ready_after2", 32'(ifu_ready), 0);
    chk("bp_cnt1", stall_cnt, 1);
    ifu_inst = 32'h00000013;
    ifu_pc = 32'h108;
    tick();
    tick();
    tick();
    chk("bp_ready_held", 32'(ifu_ready), 0);
    chk("bp_stall_cnt", stall_cnt, 4);
    chk("bp_head_pc", idu_pc, 32'h100);
    chk("bp_head_type3", 32'(type3), 1);
    idu_ready = 1;
    ifu_valid = 0;
    tick();
    chk("bp_second_pc", idu_pc, 32'h104);
    chk("bp_second_type3", 32'(type3), 5);
    chk("bp_cnt_after", stall_cnt, 4);
    tick();
    chk("bp_empty", 32'(idu_valid), 0);
    ifu_valid = 1;
    ifu_inst = 32'h00208833;
    ifu_pc = 32'h180;
    tick();
    chk("add_x16_ill", 32'(ill), 1);
    chk("add_x16_type3", 32'(type3), 7);
    chk("add_x16_rd", 32'(rd), 16);
    ifu_inst = 32'h00322023;
    tick();
    chk("sw_type3", 32'(type3), 2);
    chk("sw_ill", 32'(ill), 0);
    ifu_inst = 32'h0000007F;
    tick();
    chk("op7f_ill", 32'(ill), 1);
    chk("op7f_type3", 32'(type3), 7);
    ifu_inst = 32'h00000837;
    tick();
    chk("lui_x16_ill", 32'(ill), 1);
    ifu_inst = 32'h00C2A183;
    tick();
    chk("lw_type3", 32'(type3), 1);
    chk("lw_ill", 32'(ill), 0);
    ifu_valid = 0;
    tick();
    idu_ready = 0;
    ifu_valid = 1;
    ifu_inst = 32'h00510093;
    ifu_pc = 32'h200;
    tick();
    ifu_pc = 32'h204;
    tick();
    chk("fl_in_two", 32'(ifu_ready), 0);
    chk("fl_cnt_pre", stall_cnt, 5);
    flush = 1;
    idu_ready = 1;
    ifu_pc = 32'h208;
    tick();
    chk("fl_valid", 32'(idu_valid), 0);
    chk("fl_ifu_ready", 32'(ifu_ready), 1);
    flush = 0;
    ifu_valid = 0;
    tick();
    tick();
    chk("fl_still_empty", 32'(idu_valid), 0);
    chk("fl_cnt_kept", stall_cnt, 5);
    ifu_valid = 1;
    ifu_pc = 32'h300;
    tick();
    chk("fl_next_pc", idu_pc, 32'h300);
    idu_ready = 0;
    ifu_valid = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_head_stable", idu_pc, 32'h300);
    chk("sat_cnt32", stall_cnt, 25);
    chk("sat_cnt4", 32'(s_stall_cnt), 15);
    tick();
    chk("sat_cnt4_hold", 32'(s_stall_cnt), 15);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
